// File: rtl/text_overlay_pipe.sv
// -----------------------------------------------------------------------------
// text_overlay_pipe
//   Overlays a COLS x ROWS character box on a VGA-style pixel stream. The
//   box starts at pixel (X0, Y0). Each character cell is 8*SCALE pixels wide
//   and 16*SCALE lines high. Stage 1 decodes the box position and issues a
//   glyph lookup (char_xy / char_line) to an external font ROM. The ROM
//   answers ROM_LAT cycles later. Meanwhile the side-band (flags, bit index,
//   timing, rgb) rides a matching shift pipeline. An output stage then
//   registers the colour decision. Input-to-output latency is ROM_LAT+2
//   cycles for every output.
//
//   A cursor cell is inverted while the blink phase is 0. The blink phase
//   toggles every BLINK_FRAMES rising edges of vblnk_in.
//
// Ports
//   pclk, rst                 pixel clock, synchronous active-high reset
//   hcount_in, vcount_in      incoming pixel coordinates (11 bit)
//   hsync/hblnk/vsync/vblnk_in incoming timing strobes
//   rgb_in                    incoming 12-bit pixel colour
//   char_pixels               glyph line from the font ROM, bit 7 = leftmost
//   cursor_en/col/row         cursor enable and cell position
//   char_xy, char_line        registered font lookup address {row,col}, line
//   *_out                     timing and colour, delayed ROM_LAT+2 cycles
// -----------------------------------------------------------------------------
module text_overlay_pipe #(
  parameter int          X0           = 336,
  parameter int          Y0           = 500,
  parameter int          COLS         = 16,
  parameter int          ROWS         = 2,
  parameter int          SCALE        = 1,
  parameter int          ROM_LAT      = 2,
  parameter logic [11:0] FG           = 12'h444,
  parameter logic [11:0] BG           = 12'h7af,
  parameter int          OPAQUE       = 0,
  parameter int          BLINK_FRAMES = 30,
  localparam int         CW           = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int         RW           = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [10:0]      hcount_in,
  input  logic [10:0]      vcount_in,
  input  logic             hsync_in,
  input  logic             hblnk_in,
  input  logic             vsync_in,
  input  logic             vblnk_in,
  input  logic [11:0]      rgb_in,
  input  logic [7:0]       char_pixels,
  input  logic             cursor_en,
  input  logic [CW-1:0]    cursor_col,
  input  logic [RW-1:0]    cursor_row,
  output logic [RW+CW-1:0] char_xy,
  output logic [3:0]       char_line,
  output logic [10:0]      hcount_out,
  output logic [10:0]      vcount_out,
  output logic             hsync_out,
  output logic             hblnk_out,
  output logic             vsync_out,
  output logic             vblnk_out,
  output logic [11:0]      rgb_out
);

  // SCALE is 1 or 2, so the divide by SCALE is a shift.
  localparam int          SSH        = (SCALE == 2) ? 1 : 0;
  // One extra bit keeps the box bounds from overflowing the compare.
  localparam logic [11:0] X_LO       = 12'(X0);
  localparam logic [11:0] X_HI       = 12'(X0 + COLS * 8 * SCALE);
  localparam logic [11:0] Y_LO       = 12'(Y0);
  localparam logic [11:0] Y_HI       = 12'(Y0 + ROWS * 16 * SCALE);
  localparam logic [7:0]  FRAME_LAST = 8'(BLINK_FRAMES - 1);

  // Per-pixel side-band. Each pixel carries its own flags, so a coordinate
  // wrap mid-pipeline cannot disturb data already in flight.
  typedef struct packed {
    logic        in_box;
    logic        cur;     // cursor hit while the cursor is visible
    logic [2:0]  bidx;
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs;
    logic        hb;
    logic        vs;
    logic        vb;
    logic [11:0] rgb;
  } side_t;

  logic [11:0]      hc_w;
  logic [11:0]      vc_w;
  logic [11:0]      dx;
  logic [11:0]      dy;
  logic             in_box;
  logic             cursor_on;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  side_t            sb_d;
  side_t            sb_q [ROM_LAT+1];
  side_t            tail;
  logic [RW+CW-1:0] char_xy_d;
  logic [RW+CW-1:0] char_xy_q;
  logic [3:0]       char_line_d;
  logic [3:0]       char_line_q;
  logic             pix;
  logic [11:0]      rgb_d;
  logic [11:0]      rgb_q;
  logic [10:0]      hcount_q;
  logic [10:0]      vcount_q;
  logic             hsync_q;
  logic             hblnk_q;
  logic             vsync_q;
  logic             vblnk_q;
  logic [7:0]       frame_d;
  logic [7:0]       frame_q;
  logic             blink_d;
  logic             blink_q;
  logic             vblnk_prev_q;

  // Stage-1 decode: box test, cell/line/bit position, cursor hit.
  always_comb begin
    hc_w        = {1'b0, hcount_in};
    vc_w        = {1'b0, vcount_in};
    in_box      = (hc_w >= X_LO) && (hc_w < X_HI) && (vc_w >= Y_LO) && (vc_w < Y_HI);
    dx          = (hc_w - X_LO) >> SSH;
    dy          = (vc_w - Y_LO) >> SSH;
    col         = CW'(dx >> 3);
    row         = RW'(dy >> 4);
    // Inside the box col < COLS and row < ROWS, so an out-of-range cursor
    // never matches. The blink phase is folded in here so the visibility
    // travels with the pixel.
    cursor_on   = in_box && cursor_en && (col == cursor_col) && (row == cursor_row) && !blink_q;
    sb_d        = '0;
    char_xy_d   = '0;
    char_line_d = 4'd0;
    if (in_box) begin
      sb_d.bidx   = 3'd7 - dx[2:0];
      char_xy_d   = {row, col};
      char_line_d = dy[3:0];
    end else begin
      sb_d.bidx   = 3'd0;
    end
    sb_d.in_box = in_box;
    sb_d.cur    = cursor_on;
    sb_d.hc     = hcount_in;
    sb_d.vc     = vcount_in;
    sb_d.hs     = hsync_in;
    sb_d.hb     = hblnk_in;
    sb_d.vs     = vsync_in;
    sb_d.vb     = vblnk_in;
    sb_d.rgb    = rgb_in;
  end

  // Stage-1 registers plus a side-band shift pipeline that matches ROM latency.
  always_ff @(posedge pclk) begin
    if (rst) begin
      char_xy_q   <= '0;
      char_line_q <= 4'd0;
      for (int i = 0; i <= ROM_LAT; i++) begin
        sb_q[i] <= '0;
      end
    end else begin
      char_xy_q   <= char_xy_d;
      char_line_q <= char_line_d;
      sb_q[0]     <= sb_d;
      for (int i = 1; i <= ROM_LAT; i++) begin
        sb_q[i] <= sb_q[i-1];
      end
    end
  end

  // Frame counter and blink phase, advanced on vblnk_in rising edges.
  always_comb begin
    frame_d = frame_q;
    blink_d = blink_q;
    if (vblnk_in && !vblnk_prev_q) begin
      if (frame_q == FRAME_LAST) begin
        frame_d = 8'd0;
        blink_d = !blink_q;
      end else begin
        frame_d = frame_q + 8'd1;
      end
    end else begin
      frame_d = frame_q;
    end
  end

  // Frame counter, blink phase and previous-vblnk registers.
  always_ff @(posedge pclk) begin
    if (rst) begin
      frame_q      <= 8'd0;
      blink_q      <= 1'b0;
      vblnk_prev_q <= 1'b0;
    end else begin
      frame_q      <= frame_d;
      blink_q      <= blink_d;
      vblnk_prev_q <= vblnk_in;
    end
  end

  // Colour decision for the pixel whose glyph line is now on char_pixels.
  always_comb begin
    tail = sb_q[ROM_LAT];
    pix  = char_pixels[tail.bidx] ^ tail.cur;
    if (tail.hb || tail.vb) begin
      rgb_d = 12'h000;
    end else if (!tail.in_box) begin
      rgb_d = tail.rgb;
    end else if (pix) begin
      rgb_d = FG;
    end else if (OPAQUE != 0) begin
      rgb_d = BG;
    end else begin
      rgb_d = tail.rgb;
    end
  end

  // Output stage registers.
  always_ff @(posedge pclk) begin
    if (rst) begin
      rgb_q    <= 12'h000;
      hcount_q <= 11'd0;
      vcount_q <= 11'd0;
      hsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vsync_q  <= 1'b0;
      vblnk_q  <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      hcount_q <= tail.hc;
      vcount_q <= tail.vc;
      hsync_q  <= tail.hs;
      hblnk_q  <= tail.hb;
      vsync_q  <= tail.vs;
      vblnk_q  <= tail.vb;
    end
  end

  assign char_xy    = char_xy_q;
  assign char_line  = char_line_q;
  assign rgb_out    = rgb_q;
  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign hsync_out  = hsync_q;
  assign hblnk_out  = hblnk_q;
  assign vsync_out  = vsync_q;
  assign vblnk_out  = vblnk_q;

endmodule

// File: doc/text_overlay_pipe.md
TEXT_OVERLAY_PIPE -- requirements
Module: text_overlay_pipe

Interface
REQ-001 SHALL have parameter X0, default 336: left pixel column of text box.
REQ-002 SHALL have parameter Y0, default 500: top line of text box.
REQ-003 SHALL have parameter COLS, default 16, range 1..64: character columns.
REQ-004 SHALL have parameter ROWS, default 2, range 1..32: character rows.
REQ-005 SHALL have parameter SCALE, default 1, values 1 or 2: pixel replication factor; cell is 8*SCALE wide and 16*SCALE high.
REQ-006 SHALL have parameter ROM_LAT, default 2, range 1..4: cycles from char_xy/char_line registered to char_pixels valid.
REQ-007 SHALL have parameters FG 12'h444, BG 12'h7af, OPAQUE 0: glyph colour, box background colour, 1 = fill unset glyph pixels with BG.
REQ-008 SHALL have parameter BLINK_FRAMES, default 30, range 1..255: frames per cursor blink half-period.
REQ-009 Ports, clock and reset first: pclk in 1 pixel clock; rst in 1 reset, synchronous, active-high.
REQ-010 hcount_in, vcount_in in 11 each; hsync_in, hblnk_in, vsync_in, vblnk_in in 1 each; rgb_in in 12: incoming timing and pixel stream.
REQ-011 char_pixels in 8: glyph line from font path, bit 7 = leftmost pixel.
REQ-012 cursor_en in 1; cursor_col in CW; cursor_row in RW (CW = clog2(COLS) min 1, RW = clog2(ROWS) min 1).
REQ-013 char_xy out RW+CW = {row, col}; char_line out 4: glyph line 0..15; both registered.
REQ-014 hcount_out, vcount_out out 11; hsync_out, hblnk_out, vsync_out, vblnk_out out 1; rgb_out out 12; all registered.

Function
REQ-015 Box region SHALL be X0 <= hcount_in < X0+COLS*8*SCALE and Y0 <= vcount_in < Y0+ROWS*16*SCALE (inclusive start, exclusive end).
REQ-016 In box: dx = (hcount_in-X0)/SCALE, dy = (vcount_in-Y0)/SCALE; col = dx[..3], row = dy[..4], char_line = dy[3:0], bit index = 7-dx[2:0].
REQ-017 Stage 1 (one cycle after input) SHALL register char_xy, char_line, in-box flag, bit index, cursor-hit flag, timing and rgb_in.
REQ-018 Outside box char_xy and char_line SHALL be 0.
REQ-019 Side-band (flags, bit index, timing, rgb) SHALL be delayed ROM_LAT further cycles by a shift pipeline to align with char_pixels.
REQ-020 Output stage SHALL register the colour decision; total latency input-to-output SHALL be ROM_LAT+2 cycles for every output, including all timing signals.
REQ-021 Colour: pix = char_pixels[bit index]; cursor-hit and cursor visible inverts pix; pix=1 -> FG; pix=0 -> BG if OPAQUE else rgb_in (delayed); out of box -> rgb_in (delayed).
REQ-022 Blanking: when delayed hblnk or vblnk is 1, rgb_out SHALL be 12'h000.
REQ-023 Cursor-hit SHALL be in-box AND cursor_en AND row==cursor_row AND col==cursor_col, sampled at stage 1.
REQ-024 Frame counter (8 bit) SHALL increment on each vblnk_in rising edge; at BLINK_FRAMES-1 it SHALL wrap to 0 and toggle blink phase.
REQ-025 Blink phase 0 = cursor visible, 1 = hidden.
REQ-026 cursor_col >= COLS or cursor_row >= ROWS SHALL never hit; no error flagged.
REQ-027 hcount or vcount wrapping to 0 mid-pipeline SHALL not disturb in-flight data; each pixel carries its own flags.

Reset
REQ-028 On rst all pipeline registers and outputs SHALL go to 0, frame counter 0, blink phase 0, previous-vblnk register 0.
REQ-029 rst asserted mid-frame SHALL flush pipeline; outputs valid again ROM_LAT+2 cycles after rst deasserts.

Verification
REQ-030 Defaults, hcount_in=336, vcount_in=500, char_pixels=8'h80 at ROM_LAT cycles later -> char_xy=0, char_line=0 after 1 cycle; rgb_out=12'h444 after 4 cycles.
REQ-031 hcount_in=335 and 464, vcount_in=500 -> out of box, rgb_out=rgb_in delayed 4 cycles; char_xy=0.
REQ-032 SCALE=2, hcount_in=X0+17, vcount_in=Y0+33 -> col=1, row=1, char_line=0, bit index 7.
REQ-033 cursor_en=1, cursor at (0,0), char_pixels=8'h00, BLINK_FRAMES=2 -> cell pixels FG for 2 frames, then rgb_in for 2 frames, repeating.
REQ-034 OPAQUE=1, char_pixels=8'h00 in box -> BG 12'h7af; with hblnk_in=1 -> 12'h000.
REQ-035 rst pulsed for 1 cycle mid-line -> all outputs 0 next cycle, frame counter 0, correct data resumes 4 cycles after release.
